// File: rtl/led_nios_mem_loader_if.sv
// Byte-stream and Avalon s1 signal bundle for the NIOS memory loader.
// master: loader view (sinks the byte stream, drives the memory bus).
// slave:  environment view (sources the byte stream, owns the memory).
interface led_nios_mem_loader_if #(
    parameter int unsigned ADDR_W = 13
);
    logic [7:0]        byte_data;
    logic              byte_valid;
    logic              byte_last;
    logic              byte_ready;
    logic [ADDR_W-1:0] address;
    logic [3:0]        byteenable;
    logic              chipselect;
    logic              write;
    logic [31:0]       writedata;
    logic [31:0]       readdata;

    modport master (
        input  byte_data, byte_valid, byte_last, readdata,
        output byte_ready, address, byteenable, chipselect, write, writedata
    );

    modport slave (
        output byte_data, byte_valid, byte_last, readdata,
        input  byte_ready, address, byteenable, chipselect, write, writedata
    );
endinterface

// File: rtl/led_nios_mem_loader.sv
// Boot loader: packs a byte stream little-endian into 32-bit words and
// writes them sequentially from word 0 into the NIOS on-chip memory.
// Ports: clk, reset_n (sync, active low), start pulse, bus (stream + s1),
//        busy/done/error status, word_count, 8-bit additive checksum.
// Optional read-back verify after each write: LED_NIOS_LOADER_VERIFY_EN.
module led_nios_mem_loader #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DEPTH  = 5000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    led_nios_mem_loader_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [ADDR_W:0]      word_count,
    output logic [7:0]           checksum
);
    localparam int unsigned    CNT_W   = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = DEPTH[CNT_W-1:0];
    localparam logic [CNT_W-1:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE, S_COLLECT, S_WRITE, S_VRD, S_VCMP, S_DONE, S_ERROR
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       lane_q, lane_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      wd_q, wd_d;
    logic [CNT_W-1:0] addr_q, addr_d;   // one bit wider so DEPTH is reachable
    logic [CNT_W-1:0] wc_q, wc_d;
    logic [7:0]       cs_q, cs_d;
    logic             last_q, last_d;
    logic             ready_q, csel_q, wr_q, busy_q, done_q, err_q;

    logic accept_c, overflow_c, word_end_c, mismatch_c;

    assign accept_c   = (state_q == S_COLLECT) && ready_q && bus.byte_valid;
    assign overflow_c = (addr_q >= DEPTH_C);
    assign word_end_c = (lane_q == 2'd3) || bus.byte_last;

`ifdef LED_NIOS_LOADER_VERIFY_EN
    logic [31:0] lane_mask_c;
    assign lane_mask_c = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
    assign mismatch_c  = ((bus.readdata ^ wd_q) & lane_mask_c) != 32'd0;
`else
    logic unused_readdata;
    assign unused_readdata = ^bus.readdata;
    assign mismatch_c      = 1'b0;
`endif

    // State and all output/datapath registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            lane_q  <= 2'd0;
            be_q    <= 4'd0;
            wd_q    <= 32'd0;
            addr_q  <= '0;
            wc_q    <= '0;
            cs_q    <= 8'd0;
            last_q  <= 1'b0;
            ready_q <= 1'b0;
            csel_q  <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            be_q    <= be_d;
            wd_q    <= wd_d;
            addr_q  <= addr_d;
            wc_q    <= wc_d;
            cs_q    <= cs_d;
            last_q  <= last_d;
            ready_q <= (state_d == S_COLLECT);
            csel_q  <= (state_d == S_WRITE) || (state_d == S_VRD);
            wr_q    <= (state_d == S_WRITE);
            busy_q  <= (state_d == S_COLLECT) || (state_d == S_WRITE) ||
                       (state_d == S_VRD) || (state_d == S_VCMP);
            done_q  <= (state_d == S_DONE);
            err_q   <= (state_d == S_ERROR);
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: if (start) state_d = S_COLLECT;
            S_COLLECT: begin
                if (accept_c) begin
                    if (overflow_c)      state_d = S_ERROR;
                    else if (word_end_c) state_d = S_WRITE;
                end
            end
`ifdef LED_NIOS_LOADER_VERIFY_EN
            S_WRITE: state_d = S_VRD;
            S_VRD:   state_d = S_VCMP;
            S_VCMP:  state_d = mismatch_c ? S_ERROR : (last_q ? S_DONE : S_COLLECT);
`else
            S_WRITE: state_d = last_q ? S_DONE : S_COLLECT;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: lane packing, counters, checksum.
    always_comb begin
        lane_d = lane_q;
        be_d   = be_q;
        wd_d   = wd_q;
        addr_d = addr_q;
        wc_d   = wc_q;
        cs_d   = cs_q;
        last_d = last_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    lane_d = 2'd0;
                    be_d   = 4'd0;
                    wd_d   = 32'd0;
                    addr_d = '0;
                    wc_d   = '0;
                    cs_d   = 8'd0;
                    last_d = 1'b0;
                end
            end
            S_COLLECT: begin
                // Overflowing byte is dropped: nothing packed, nothing summed.
                if (accept_c && !overflow_c) begin
                    wd_d[{lane_q, 3'b000} +: 8] = bus.byte_data;
                    be_d[lane_q]                = 1'b1;
                    cs_d                        = cs_q + bus.byte_data;
                    last_d                      = bus.byte_last;
                    if (!word_end_c) lane_d = lane_q + 2'd1;
                end
            end
            S_WRITE: begin
                wc_d = wc_q + ONE_C;
`ifndef LED_NIOS_LOADER_VERIFY_EN
                if (!last_q) begin
                    addr_d = addr_q + ONE_C;
                    lane_d = 2'd0;
                    be_d   = 4'd0;
                    wd_d   = 32'd0;
                end
`endif
            end
`ifdef LED_NIOS_LOADER_VERIFY_EN
            S_VCMP: begin
                if (!mismatch_c && !last_q) begin
                    addr_d = addr_q + ONE_C;
                    lane_d = 2'd0;
                    be_d   = 4'd0;
                    wd_d   = 32'd0;
                end
            end
`endif
            default: ;
        endcase
    end

    assign bus.byte_ready = ready_q;
    assign bus.address    = addr_q[ADDR_W-1:0];
    assign bus.byteenable = be_q;
    assign bus.chipselect = csel_q;
    assign bus.write      = wr_q;
    assign bus.writedata  = wd_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = err_q;
    assign word_count     = wc_q;
    assign checksum       = cs_q;
endmodule

// File: tb/tb_led_nios_mem_loader.sv
module tb_led_nios_mem_loader;
    localparam int unsigned ADDR_W = 13;
    localparam int unsigned DEPTH  = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic busy, done, error;
    logic [ADDR_W:0] word_count;
    logic [7:0]      checksum;

    always #5 clk = ~clk;

    led_nios_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    led_nios_mem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .word_count (word_count),
        .checksum   (checksum)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic [3:0]        be;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] img[$];
    int         m_wc;
    logic [7:0] m_cs;
    bit         m_err;
    int         n_vec = 0;
    int         n_err = 0;
    bit         corrupt = 1'b0;
    logic [31:0] mem [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Memory behind s1: byte-lane writes, one-cycle read latency, optional bit-0 corruption at word 0.
    always @(posedge clk) begin
        if (!reset_n) bus.readdata <= 32'd0;
        else if (bus.chipselect && !bus.write)
            bus.readdata <= mem[bus.address[2:0]] ^ {31'd0, corrupt && (bus.address == '0)};
        if (bus.chipselect && bus.write)
            for (int k = 0; k < 4; k++)
                if (bus.byteenable[k]) mem[bus.address[2:0]][8*k +: 8] <= bus.writedata[8*k +: 8];
    end

    // Every write strobe must match the next expected write.
    always @(negedge clk) begin
        if (reset_n && bus.chipselect && bus.write) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(bus.address), 64'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 64'(bus.address), 64'(e.addr));
                check("wr_data", 64'(bus.writedata), 64'(e.data));
                check("wr_be",   64'(bus.byteenable), 64'(e.be));
            end
        end
    end

    // Reference: walk the image, cut words at 4 bytes or the last byte, stop at DEPTH.
    task automatic model();
        int   w = 0;
        int   lane = 0;
        logic [31:0] data = 32'd0;
        logic [3:0]  be = 4'd0;
        wr_t  t;
        m_cs  = 8'd0;
        m_err = 1'b0;
        for (int i = 0; i < img.size(); i++) begin
            if (w >= int'(DEPTH)) begin
                m_err = 1'b1;
                break;
            end
            data[8*lane +: 8] = img[i];
            be[lane] = 1'b1;
            m_cs = m_cs + img[i];
            if (lane == 3 || i == img.size() - 1) begin
                t.addr = ADDR_W'(w);
                t.data = data;
                t.be   = be;
                exp_q.push_back(t);
                w++;
                lane = 0;
                data = 32'd0;
                be   = 4'd0;
            end else begin
                lane++;
            end
        end
        m_wc = w;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last, output bit ok);
        bit acc = 1'b0;
        bus.byte_data  = b;
        bus.byte_last  = last;
        bus.byte_valid = 1'b1;
        for (int c = 0; c < 20 && !acc; c++) begin
            acc = bus.byte_ready;
            @(negedge clk);
        end
        bus.byte_valid = 1'b0;
        bus.byte_last  = 1'b0;
        ok = acc;
        if (!acc) check("byte_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_image(input int gap, input int stray_at);
        bit ok;
        for (int i = 0; i < img.size(); i++) begin
            send_byte(img[i], i == img.size() - 1, ok);
            if (!ok) return;
            for (int g = 0; g < gap; g++) begin
                start = (i == stray_at);
                @(negedge clk);
                start = 1'b0;
            end
        end
    endtask

    task automatic wait_end();
        int c = 0;
        while (!(done || error) && c < 40) begin
            @(negedge clk);
            c++;
        end
        if (!(done || error)) check("end_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_image(input string tag, input int gap, input int stray_at);
        pulse_start();
        send_image(gap, stray_at);
        wait_end();
        check({tag, "_done"},  64'(done),  64'(!m_err));
        check({tag, "_error"}, 64'(error), 64'(m_err));
        check({tag, "_busy"},  64'(busy),  64'd0);
        check({tag, "_wc"},    64'(word_count), 64'(m_wc));
        check({tag, "_cs"},    64'(checksum),   64'(m_cs));
        check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, 64'(bus.byte_ready), 64'd0);
        check({tag, "_csel"},  64'(bus.chipselect), 64'd0);
        check({tag, "_write"}, 64'(bus.write), 64'd0);
        check({tag, "_busy"},  64'(busy), 64'd0);
        check({tag, "_done"},  64'(done), 64'd0);
        check({tag, "_error"}, 64'(error), 64'd0);
        check({tag, "_addr"},  64'(bus.address), 64'd0);
        check({tag, "_be"},    64'(bus.byteenable), 64'd0);
        check({tag, "_wd"},    64'(bus.writedata), 64'd0);
        check({tag, "_wc"},    64'(word_count), 64'd0);
        check({tag, "_cs"},    64'(checksum), 64'd0);
    endtask

    initial begin
        bit ok;
        bus.byte_data  = 8'd0;
        bus.byte_valid = 1'b0;
        bus.byte_last  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Full word.
        img = '{8'h11, 8'h22, 8'h33, 8'h44};
        model();
        check("pin_full_n",    64'(exp_q.size()), 64'd1);
        check("pin_full_data", 64'(exp_q[0].data), 64'h4433_2211);
        check("pin_full_be",   64'(exp_q[0].be), 64'hF);
        check("pin_full_cs",   64'(m_cs), 64'hAA);
        run_image("full", 0, -1);

        // Partial trailing word.
        img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        model();
        check("pin_part_data1", 64'(exp_q[1].data), 64'h0000_0605);
        check("pin_part_be1",   64'(exp_q[1].be), 64'h3);
        check("pin_part_addr1", 64'(exp_q[1].addr), 64'd1);
        check("pin_part_cs",    64'(m_cs), 64'h15);
        run_image("part", 0, -1);

        // Overflow past DEPTH words.
        img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
        model();
        check("pin_ovf_n",   64'(exp_q.size()), 64'd2);
        check("pin_ovf_err", 64'(m_err), 64'd1);
        check("pin_ovf_cs",  64'(m_cs), 64'h24);
        run_image("ovf", 0, -1);

        // Backpressure with a stray start while busy.
        img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        model();
        run_image("bp", 1, 2);

        // Reset in the middle of a word.
        pulse_start();
        send_byte(8'hA1, 1'b0, ok);
        send_byte(8'hA2, 1'b0, ok);
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_vals("midrst");
        reset_n = 1'b1;
        @(negedge clk);

        // Recovery after reset.
        img = '{8'h11, 8'h22, 8'h33, 8'h44};
        model();
        run_image("recov", 0, -1);

`ifdef LED_NIOS_LOADER_VERIFY_EN
        // Corrupted read-back at word 0.
        corrupt = 1'b1;
        img = '{8'h11, 8'h22, 8'h33, 8'h44};
        model();
        m_err = 1'b1;
        run_image("verify", 0, -1);
        corrupt = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
